// File: rtl/controlador_cursor_jogada_if.sv
// Signal bundle between the shot-entry controller and the buttons/board-lookup side.
// The master drives the buttons and the lookup response. The slave (the controller) drives the cursor and the status outputs.
interface controlador_cursor_jogada_if;
  logic       btn_cima;
  logic       btn_baixo;
  logic       btn_esq;
  logic       btn_dir;
  logic       btn_conf;
  logic       ack_consulta;
  logic       acerto_in;
  logic [2:0] mdc;
  logic [2:0] mdl;
  logic       req_consulta;
  logic [3:0] jogadas;
  logic [3:0] acertos;
  logic       ultimo_acerto;
  logic       resultado_valido;
  logic       fim_jogo;
  logic       vitoria;

  modport master (
    output btn_cima, btn_baixo, btn_esq, btn_dir, btn_conf, ack_consulta, acerto_in,
    input  mdc, mdl, req_consulta, jogadas, acertos, ultimo_acerto,
           resultado_valido, fim_jogo, vitoria
  );

  modport slave (
    input  btn_cima, btn_baixo, btn_esq, btn_dir, btn_conf, ack_consulta, acerto_in,
    output mdc, mdl, req_consulta, jogadas, acertos, ultimo_acerto,
           resultado_valido, fim_jogo, vitoria
  );
endinterface

// File: rtl/controlador_cursor_jogada.sv
// Cursor, shot handshake and score keeper for the LED-matrix game.
// Button levels become single-cycle press events. Every output is registered.
module controlador_cursor_jogada #(
  parameter int COL_MAX     = 4,
  parameter int LIN_MAX     = 6,
  parameter int MAX_JOGADAS = 15,
  parameter int ALVOS       = 9,
  parameter int RES_CICLOS  = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  controlador_cursor_jogada_if.slave io_bus
);
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RES_W = (RES_CICLOS > 1) ? $clog2(RES_CICLOS) : 1;
  localparam logic [2:0]       L_COL_MAX  = 3'(COL_MAX);
  localparam logic [2:0]       L_LIN_MAX  = 3'(LIN_MAX);
  localparam logic [3:0]       L_MAX_JOG  = 4'(MAX_JOGADAS);
  localparam logic [3:0]       L_ALVOS    = 4'(ALVOS);
  localparam logic [TO_W-1:0]  L_TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [RES_W-1:0] L_RES_LAST = RES_W'(RES_CICLOS - 1);

  typedef enum logic [1:0] {SELECAO, CONSULTA, RESULTADO, FIM} estado_t;

  estado_t          r_estado;
  logic [4:0]       r_btn_prev;
  logic [2:0]       r_mdc;
  logic [2:0]       r_mdl;
  logic             r_req;
  logic [3:0]       r_jogadas;
  logic [3:0]       r_acertos;
  logic             r_ultimo;
  logic             r_res_valido;
  logic             r_fim;
  logic             r_vitoria;
  logic [TO_W-1:0]  r_timeout;
  logic [RES_W-1:0] r_res_cnt;

  logic [4:0] w_btn;
  logic [4:0] w_ev;
  logic [2:0] w_mdc_next;
  logic [2:0] w_mdl_next;
  logic       w_consulta_fim;
  logic       w_acerto;

  // Bit order {conf, dir, esq, baixo, cima}. A press is a single-cycle rising edge.
  assign w_btn = {io_bus.btn_conf, io_bus.btn_dir, io_bus.btn_esq,
                  io_bus.btn_baixo, io_bus.btn_cima};
  assign w_ev  = w_btn & ~r_btn_prev;

  // Opposite presses on one axis cancel. Otherwise the cursor moves one step and saturates at the edges.
  always_comb begin
    w_mdc_next = r_mdc;
    w_mdl_next = r_mdl;
    if (w_ev[3] && !w_ev[2] && r_mdc != L_COL_MAX)
      w_mdc_next = r_mdc + 3'd1;
    else if (w_ev[2] && !w_ev[3] && r_mdc != 3'd0)
      w_mdc_next = r_mdc - 3'd1;
    if (w_ev[1] && !w_ev[0] && r_mdl != L_LIN_MAX)
      w_mdl_next = r_mdl + 3'd1;
    else if (w_ev[0] && !w_ev[1] && r_mdl != 3'd0)
      w_mdl_next = r_mdl - 3'd1;
  end

  assign w_consulta_fim = io_bus.ack_consulta || (r_timeout == L_TO_LAST);
  assign w_acerto       = io_bus.ack_consulta && io_bus.acerto_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado     <= SELECAO;
      r_btn_prev   <= '0;
      r_mdc        <= '0;
      r_mdl        <= '0;
      r_req        <= 1'b0;
      r_jogadas    <= '0;
      r_acertos    <= '0;
      r_ultimo     <= 1'b0;
      r_res_valido <= 1'b0;
      r_fim        <= 1'b0;
      r_vitoria    <= 1'b0;
      r_timeout    <= '0;
      r_res_cnt    <= '0;
    end else begin
      r_btn_prev <= w_btn;
      case (r_estado)
        SELECAO: begin
          if (w_ev[4]) begin
            r_estado  <= CONSULTA;
            r_req     <= 1'b1;
            r_timeout <= '0;
          end else begin
            r_mdc <= w_mdc_next;
            r_mdl <= w_mdl_next;
          end
        end
        // An ack outranks a timeout that expires in the same cycle. A timeout counts as a miss.
        CONSULTA: begin
          if (w_consulta_fim) begin
            r_ultimo     <= w_acerto;
            r_jogadas    <= r_jogadas + 4'd1;
            if (w_acerto)
              r_acertos <= r_acertos + 4'd1;
            r_req        <= 1'b0;
            r_res_valido <= 1'b1;
            r_res_cnt    <= '0;
            r_estado     <= RESULTADO;
          end else begin
            r_timeout <= r_timeout + 1'b1;
          end
        end
        RESULTADO: begin
          if (r_res_cnt == L_RES_LAST) begin
            r_res_valido <= 1'b0;
            if (r_acertos == L_ALVOS || r_jogadas == L_MAX_JOG) begin
              r_estado  <= FIM;
              r_fim     <= 1'b1;
              r_vitoria <= (r_acertos == L_ALVOS);
            end else begin
              r_estado <= SELECAO;
            end
          end else begin
            r_res_cnt <= r_res_cnt + 1'b1;
          end
        end
        FIM: begin
          if (w_ev[4]) begin
            r_estado  <= SELECAO;
            r_jogadas <= '0;
            r_acertos <= '0;
            r_ultimo  <= 1'b0;
            r_mdc     <= '0;
            r_mdl     <= '0;
            r_fim     <= 1'b0;
            r_vitoria <= 1'b0;
          end
        end
        default: r_estado <= SELECAO;
      endcase
    end
  end

  assign io_bus.mdc              = r_mdc;
  assign io_bus.mdl              = r_mdl;
  assign io_bus.req_consulta     = r_req;
  assign io_bus.jogadas          = r_jogadas;
  assign io_bus.acertos          = r_acertos;
  assign io_bus.ultimo_acerto    = r_ultimo;
  assign io_bus.resultado_valido = r_res_valido;
  assign io_bus.fim_jogo         = r_fim;
  assign io_bus.vitoria          = r_vitoria;
endmodule
